// File: rtl/recall_pkg.sv
// Shared codes for the recall readout: group verdicts,
// FSM states and the group-to-neuron map.
package recall_pkg;

  localparam logic [1:0] GRP_NONE  = 2'b00;
  localparam logic [1:0] GRP_A     = 2'b01;
  localparam logic [1:0] GRP_B     = 2'b10;
  localparam logic [1:0] GRP_AMBIG = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    DECIDE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // Group A = neurons 0/1, group B = neurons 2/3
  localparam int A_LO = 0;
  localparam int A_HI = 1;
  localparam int B_LO = 2;
  localparam int B_HI = 3;

endpackage

// File: rtl/recall_readout_spike_counter.sv
// Saturating per-neuron spike counter with sync clear and enable.
// Ports: clk, rst, i_clr, i_en, i_spike -> o_cnt (CNT_W bits).
module spike_counter
  import recall_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_spike,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  // Stop at all-ones so a busy neuron never wraps to a small count
  always_ff @(posedge clk) begin
    if (rst || i_clr)
      r_cnt <= '0;
    else if (i_en && i_spike && (r_cnt != '1))
      r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/recall_readout.sv
// Recall readout: counts spikes per neuron over a window and
// reports which ensemble (A = N0/N1, B = N2/N3) was recalled.
// Ports: clk, rst (sync, active-high), spike_in[3:0],
//   win_start, out_ready -> out_valid, out_group[1:0],
//   out_cnt_a/out_cnt_b [CNT_W:0], busy.
// Option: RECALL_COACT_EN -- a group only counts toward the
//   verdict when both of its neurons fired at least once.
module recall_readout
  import recall_pkg::*;
#(
  parameter int WIN_LEN    = 32,
  parameter int CNT_W      = 6,
  parameter int MIN_SPIKES = 4,
  parameter int MARGIN     = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     spike_in,
  input  logic           win_start,
  input  logic           out_ready,
  output logic           out_valid,
  output logic [1:0]     out_group,
  output logic [CNT_W:0] out_cnt_a,
  output logic [CNT_W:0] out_cnt_b,
  output logic           busy
);

  localparam int SW = CNT_W + 1;
  localparam int CW = CNT_W + 2;
  localparam int WW = $clog2(WIN_LEN);

  state_t         r_state;
  logic [WW-1:0]  r_win;
  logic           r_valid;
  logic [1:0]     r_group;
  logic [SW-1:0]  r_cnt_a;
  logic [SW-1:0]  r_cnt_b;
  logic           r_busy;

  logic [CNT_W-1:0] w_cnt [4];
  logic             w_clr;
  logic             w_en;
  logic [SW-1:0]    w_sum_a;
  logic [SW-1:0]    w_sum_b;
  logic [SW-1:0]    w_dec_a;
  logic [SW-1:0]    w_dec_b;
  logic [CW-1:0]    w_ea;
  logic [CW-1:0]    w_eb;
  logic [CW-1:0]    w_max;
  logic [1:0]       w_grp;

  // The win_start cycle only clears; sampling starts next cycle
  assign w_clr = (r_state == IDLE) && win_start;
  assign w_en  = (r_state == COUNT);

  for (genvar g = 0; g < 4; g++) begin : g_cnt
    spike_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (w_clr),
      .i_en    (w_en),
      .i_spike (spike_in[g]),
      .o_cnt   (w_cnt[g])
    );
  end

  assign w_sum_a = SW'(w_cnt[A_LO]) + SW'(w_cnt[A_HI]);
  assign w_sum_b = SW'(w_cnt[B_LO]) + SW'(w_cnt[B_HI]);

`ifdef RECALL_COACT_EN
  // A partial ensemble is not a completed pattern
  assign w_dec_a = ((w_cnt[A_LO] != '0) && (w_cnt[A_HI] != '0))
                 ? w_sum_a : '0;
  assign w_dec_b = ((w_cnt[B_LO] != '0) && (w_cnt[B_HI] != '0))
                 ? w_sum_b : '0;
`else
  assign w_dec_a = w_sum_a;
  assign w_dec_b = w_sum_b;
`endif

  // One spare bit so the margin add cannot overflow
  assign w_ea  = CW'(w_dec_a);
  assign w_eb  = CW'(w_dec_b);
  assign w_max = (w_ea >= w_eb) ? w_ea : w_eb;

  always_comb begin
    w_grp = GRP_AMBIG;
    if (w_max < CW'(MIN_SPIKES))
      w_grp = GRP_NONE;
    else if (w_ea >= w_eb + CW'(MARGIN))
      w_grp = GRP_A;
    else if (w_eb >= w_ea + CW'(MARGIN))
      w_grp = GRP_B;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_win   <= '0;
      r_valid <= 1'b0;
      r_group <= GRP_NONE;
      r_cnt_a <= '0;
      r_cnt_b <= '0;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (win_start) begin
            r_state <= COUNT;
            r_win   <= '0;
            r_busy  <= 1'b1;
          end
        end
        COUNT: begin
          if (r_win == WW'(WIN_LEN - 1))
            r_state <= DECIDE;
          else
            r_win <= r_win + 1'b1;
        end
        DECIDE: begin
          r_group <= w_grp;
          r_cnt_a <= w_sum_a;
          r_cnt_b <= w_sum_b;
          r_valid <= 1'b1;
          r_state <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid = r_valid;
  assign out_group = r_group;
  assign out_cnt_a = r_cnt_a;
  assign out_cnt_b = r_cnt_b;
  assign busy      = r_busy;

endmodule

// File: tb/tb_recall_readout.sv
// Directed bench for recall_readout: table-driven windows plus
// reset, saturation, backpressure and abort sequences.
module tb_recall_readout;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] spike_in = 4'b0;
  logic       win_start = 1'b0;
  logic       out_ready = 1'b0;

  logic       m_valid, m_busy;
  logic [1:0] m_group;
  logic [6:0] m_cnt_a, m_cnt_b;

  logic       s_valid, s_busy;
  logic [1:0] s_group;
  logic [4:0] s_cnt_a, s_cnt_b;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  recall_readout u_dut (
    .clk       (clk),
    .rst       (rst),
    .spike_in  (spike_in),
    .win_start (win_start),
    .out_ready (out_ready),
    .out_valid (m_valid),
    .out_group (m_group),
    .out_cnt_a (m_cnt_a),
    .out_cnt_b (m_cnt_b),
    .busy      (m_busy)
  );

  recall_readout #(.CNT_W(4)) u_sat (
    .clk       (clk),
    .rst       (rst),
    .spike_in  (spike_in),
    .win_start (win_start),
    .out_ready (out_ready),
    .out_valid (s_valid),
    .out_group (s_group),
    .out_cnt_a (s_cnt_a),
    .out_cnt_b (s_cnt_b),
    .busy      (s_busy)
  );

  typedef struct {
    logic [3:0] ma;
    int         pa;
    logic [3:0] mb;
    int         pb;
    logic [1:0] grp;
    logic [1:0] grp_c;
    int         ca;
    int         cb;
  } vec_t;

  vec_t tbl [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] exp_grp(input vec_t v);
`ifdef RECALL_COACT_EN
    return v.grp_c;
`else
    return v.grp;
`endif
  endfunction

  // Opens a window, drives the pattern for 32 COUNT cycles and
  // leaves the DUT in HOLD with the verdict on the outputs.
  task automatic run_win(input vec_t v, input string nm);
    logic [3:0] sp;
    win_start = 1'b1;
    spike_in  = 4'hF;
    tick();
    win_start = 1'b0;
    chk({nm, "_busy"}, int'(m_busy), 1);
    for (int i = 0; i < 32; i++) begin
      sp = 4'b0;
      if ((i % v.pa) == 0) sp = sp | v.ma;
      if ((i % v.pb) == 0) sp = sp | v.mb;
      spike_in = sp;
      tick();
    end
    spike_in = 4'hF;
    chk({nm, "_valid_early"}, int'(m_valid), 0);
    tick();
    spike_in = 4'b0;
    chk({nm, "_valid"}, int'(m_valid), 1);
    chk({nm, "_group"}, int'(m_group), int'(exp_grp(v)));
    chk({nm, "_cnt_a"}, int'(m_cnt_a), v.ca);
    chk({nm, "_cnt_b"}, int'(m_cnt_b), v.cb);
  endtask

  task automatic accept(input string nm);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({nm, "_acc_valid"}, int'(m_valid), 0);
    chk({nm, "_acc_busy"}, int'(m_busy), 0);
  endtask

  initial begin
    logic [1:0] hold_g;
    logic [6:0] hold_a;
    int seen;

    tbl[0] = '{4'b0011, 4, 4'b0000, 1, 2'b01, 2'b01, 16, 0};
    tbl[1] = '{4'b0000, 1, 4'b1100, 4, 2'b10, 2'b10, 0, 16};
    tbl[2] = '{4'b1111, 8, 4'b0000, 1, 2'b11, 2'b11, 8, 8};
    tbl[3] = '{4'b0000, 1, 4'b0000, 1, 2'b00, 2'b00, 0, 0};
    tbl[4] = '{4'b0001, 4, 4'b0000, 1, 2'b01, 2'b00, 8, 0};
    tbl[5] = '{4'b0001, 11, 4'b0000, 1, 2'b00, 2'b00, 3, 0};
    tbl[6] = '{4'b0001, 8, 4'b0000, 1, 2'b01, 2'b00, 4, 0};
    tbl[7] = '{4'b0001, 4, 4'b0100, 5, 2'b11, 2'b00, 8, 7};
    tbl[8] = '{4'b0001, 4, 4'b0100, 6, 2'b01, 2'b00, 8, 6};
    tbl[9] = '{4'b0011, 8, 4'b1100, 7, 2'b10, 2'b10, 8, 10};

    // Reset
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_valid", int'(m_valid), 0);
    chk("rst_group", int'(m_group), 0);
    chk("rst_cnt_a", int'(m_cnt_a), 0);
    chk("rst_cnt_b", int'(m_cnt_b), 0);
    chk("rst_busy", int'(m_busy), 0);
    chk("rst_sat_busy", int'(s_busy), 0);

    // Table of windows
    for (int k = 0; k < 10; k++) begin
      run_win(tbl[k], $sformatf("vec%0d", k));
      accept($sformatf("vec%0d", k));
    end

    // Saturation on the narrow instance, then backpressure
    run_win('{4'b0001, 1, 4'b0000, 1, 2'b01, 2'b00, 32, 0}, "sat");
    chk("sat_s_cnt_a", int'(s_cnt_a), 15);
    chk("sat_s_valid", int'(s_valid), 1);
`ifdef RECALL_COACT_EN
    chk("sat_s_group", int'(s_group), 0);
`else
    chk("sat_s_group", int'(s_group), 1);
`endif
    hold_g = m_group;
    hold_a = m_cnt_a;
    for (int i = 0; i < 10; i++) begin
      win_start = i[0];
      tick();
      chk("bp_valid", int'(m_valid), 1);
      chk("bp_group", int'(m_group), int'(hold_g));
      chk("bp_cnt_a", int'(m_cnt_a), int'(hold_a));
    end
    win_start = 1'b0;
    accept("bp");
    repeat (3) tick();
    chk("bp_no_queue", int'(m_busy), 0);

    // Reset in the middle of a window
    win_start = 1'b1;
    tick();
    win_start = 1'b0;
    spike_in = 4'b0011;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    spike_in = 4'b0;
    chk("abort_busy", int'(m_busy), 0);
    chk("abort_cnt_a", int'(m_cnt_a), 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (m_valid || m_busy) seen = 1;
    end
    chk("abort_no_valid", seen, 0);
    run_win(tbl[0], "post_abort");
    accept("post_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
